data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Round-robin arbiter that shares one data bus (valid + data, no backpressure) between NumReq requester streams.
- Each requester has a valid/ready handshake. A granted owner may hold the bus for a burst of up to MaxBurst consecutive beats.
- The bus output is registered and drives the data bus interface signals. It sits between traffic sources and the bus consumer.

Parameters:
- NumReq, 4, number of requesters (2..16)
- BusWidth, minitb::BusWidth, data bus width in bits
- MaxBurst, 4, maximum consecutive beats per grant (>=1; 1 gives pure beat-level round robin)

Ports:
- clk  input  1  clock; all flops on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid_i  input  NumReq  per-requester beat valid
- req_data_i  input  NumReq*BusWidth  per-requester data; requester i occupies bits [i*BusWidth +: BusWidth]
- req_ready_o  output  NumReq  per-requester accept; one-hot or zero
- bus_valid_o  output  1  data bus valid (registered)
- bus_data_o  output  BusWidth  data bus data (registered)
- bus_owner_o  output  $clog2(NumReq)  index of the requester whose beat is on the bus (registered)
- idle_o  output  1  high when state is IDLE and no req_valid_i is high

Behaviour:
- Reset values: bus_valid_o=0, bus_data_o=0, bus_owner_o=0, state=IDLE, rr_ptr=0, beat_cnt=0.
- req_ready_o is forced to 0 while rst_n is low.
- Transfer occurs on requester i when req_valid_i[i] && req_ready_o[i].
- Latency: a beat accepted in cycle N appears on bus_valid_o/bus_data_o/bus_owner_o in cycle N+1 for exactly one cycle.
- With no transfer, bus_valid_o=0 and bus_data_o/bus_owner_o hold their last values.
- Requester rule: data stays stable and valid stays high until accepted. The arbiter does not check this rule.
- Arbitration (combinational): the winner is the first i with req_valid_i[i]=1, scanning rr_ptr, rr_ptr+1, ... modulo NumReq.
- States:
  - IDLE:
    - If any valid: ready[winner]=1, transfer.
    - Next: owner=winner, beat_cnt=1, rr_ptr=(winner+1)%NumReq, state=BURST. If MaxBurst==1, state stays IDLE.
  - BURST, owner holds (req_valid_i[owner]=1 and beat_cnt<MaxBurst):
    - ready[owner]=1, transfer, beat_cnt++.
    - When beat_cnt reaches MaxBurst: next state=IDLE.
  - BURST, owner dropped valid:
    - Re-arbitrate in the same cycle exactly as in IDLE, with no bubble.
    - The new winner may be any requester, including the former owner if it is the only one valid.
- Only one ready per cycle. Grant is never given to a requester with valid=0.
- rr_ptr wraps from NumReq-1 to 0.
- All valids low: no ready asserted, state=IDLE, rr_ptr unchanged.
- Asynchronous reset mid-burst:
  - Outputs and state clear immediately.
  - An already-registered beat is dropped from the bus.
  - After reset release, arbitration restarts from rr_ptr=0.

Optional Feature:
- Macro: DATA_BUS_ARB_STATS_EN
- Defined:
  - Adds output port grant_cnt_o, NumReq*32 bits. Slice i is a 32-bit saturating count of beats accepted from requester i.
  - Adds output port burst_cut_o, 1 bit, registered. Pulses one cycle after a burst ends on MaxBurst while the owner still has valid high.
  - All added outputs reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single requester 2 asserts valid with data 0xA5, then 0xA6 (continuous). Expect: ready[2] in cycles N and N+1; bus shows 0xA5/owner=2 at N+1 and 0xA6/owner=2 at N+2.
- All 4 requesters continuously valid, MaxBurst=4. Expect: bus owner sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0..., with no idle bubbles.
- MaxBurst=1, requesters 1 and 3 valid. Expect: owners alternate 1,3,1,3; requesters 0 and 2 never receive ready.
- Requester 0 bursts 2 beats then drops valid while requester 2 is valid. Expect: requester 2 accepted in the same cycle the valid of 0 drops; bus owner sequence 0,0,2 contiguous.
- Assert rst_n=0 during the 3rd beat of a burst. Expect: bus_valid_o=0 immediately, req_ready_o=0 during reset. After release with all valid, first owner=0.
- With DATA_BUS_ARB_STATS_EN, 10 beats from requester 1 and 3 from requester 3. Expect: grant_cnt_o slices = 0,10,0,3. Expect: burst_cut_o pulses twice for requester 1's 10-beat stream at MaxBurst=4.

Source files
------------

// File: rtl/minitb.sv
// minitb: constants shared by the mini bus blocks.
// BusWidth: default data-bus width in bits.
package minitb;
    localparam int BusWidth = 8;
endpackage

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: round-robin burst arbiter driving one registered valid/data bus.
// Ports: clk, rst_n (async, active low); req_valid_i/req_data_i/req_ready_o per requester;
//        bus_valid_o/bus_data_o/bus_owner_o registered bus side; idle_o when IDLE with no valid.
// Optional build macro DATA_BUS_ARB_STATS_EN adds grant_cnt_o (32-bit saturating beat
// counts per requester) and burst_cut_o (pulse after a burst is cut at MaxBurst).
module data_bus_arbiter #(
    parameter int NumReq   = 4,
    parameter int BusWidth = minitb::BusWidth,
    parameter int MaxBurst = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NumReq-1:0]            req_valid_i,
    input  logic [NumReq*BusWidth-1:0]   req_data_i,
    output logic [NumReq-1:0]            req_ready_o,
    output logic                         bus_valid_o,
    output logic [BusWidth-1:0]          bus_data_o,
    output logic [$clog2(NumReq)-1:0]    bus_owner_o,
    output logic                         idle_o
`ifdef DATA_BUS_ARB_STATS_EN
    ,
    output logic [NumReq*32-1:0]         grant_cnt_o,
    output logic                         burst_cut_o
`endif
);

    localparam int OwnW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    localparam logic [CntW-1:0] CntMax = CntW'(MaxBurst);
    localparam logic [CntW-1:0] CntOne = CntW'(1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]          state_q;
    logic [0:0]          state_d;
    logic [OwnW-1:0]     owner_q;
    logic [OwnW-1:0]     owner_d;
    logic [OwnW-1:0]     rr_ptr_q;
    logic [OwnW-1:0]     rr_ptr_d;
    logic [CntW-1:0]     cnt_q;
    logic [CntW-1:0]     cnt_d;

    logic                win_vld;
    logic [OwnW-1:0]     win_idx;
    logic                hold;
    logic                gnt_vld;
    logic [OwnW-1:0]     gnt_idx;
    logic [BusWidth-1:0] gnt_data;

    // (p + k) mod NumReq, with p < NumReq and k < NumReq
    function automatic logic [OwnW-1:0] wrap_add(
        input logic [OwnW-1:0] p,
        input int              k
    );
        int s;
        s = int'(p) + k;
        if (s >= NumReq) begin
            s = s - NumReq;
        end
        return OwnW'(s);
    endfunction

    // First valid requester starting at rr_ptr and wrapping around
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NumReq; k++) begin
            if (!win_vld && req_valid_i[wrap_add(rr_ptr_q, k)]) begin
                win_vld = 1'b1;
                win_idx = wrap_add(rr_ptr_q, k);
            end
        end
    end

    // Owner keeps the bus while it stays valid and has beats left
    assign hold = (state_q == BURST)
               && req_valid_i[owner_q]
               && (cnt_q < CntMax);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        gnt_vld  = 1'b0;
        gnt_idx  = owner_q;
        unique case (1'b1)
            hold: begin
                gnt_vld = 1'b1;
                cnt_d   = cnt_q + CntOne;
                state_d = (cnt_d == CntMax) ? IDLE : BURST;
            end
            // Covers both IDLE and a dropped owner, so no bubble on hand-over
            (!hold && win_vld): begin
                gnt_vld  = 1'b1;
                gnt_idx  = win_idx;
                owner_d  = win_idx;
                cnt_d    = CntOne;
                rr_ptr_d = wrap_add(win_idx, 1);
                state_d  = (MaxBurst == 1) ? IDLE : BURST;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Ready is one-hot on the grant; held low while reset is asserted
    always_comb begin
        req_ready_o = '0;
        if (gnt_vld && rst_n) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt_idx == OwnW'(i)) begin
                gnt_data = req_data_i[i*BusWidth +: BusWidth];
            end
        end
    end

    assign idle_o = (state_q == IDLE) && !(|req_valid_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Bus register: data/owner hold their last value between beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_valid_o <= 1'b0;
            bus_data_o  <= '0;
            bus_owner_o <= '0;
        end else begin
            bus_valid_o <= gnt_vld;
            if (gnt_vld) begin
                bus_data_o  <= gnt_data;
                bus_owner_o <= gnt_idx;
            end
        end
    end

`ifdef DATA_BUS_ARB_STATS_EN
    logic [31:0] stat_q [NumReq];
    logic        cap_q;

    // cap_q: last cycle accepted the final beat allowed to owner_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumReq; i++) begin
                stat_q[i] <= '0;
            end
            cap_q       <= 1'b0;
            burst_cut_o <= 1'b0;
        end else begin
            for (int i = 0; i < NumReq; i++) begin
                if (req_ready_o[i] && req_valid_i[i] && (stat_q[i] != '1)) begin
                    stat_q[i] <= stat_q[i] + 32'd1;
                end
            end
            cap_q       <= gnt_vld && (cnt_d == CntMax);
            burst_cut_o <= cap_q && req_valid_i[owner_q];
        end
    end

    for (genvar g = 0; g < NumReq; g++) begin : g_stat
        assign grant_cnt_o[g*32 +: 32] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter: directed and randomized checks of data_bus_arbiter.
// Two instances: MaxBurst=4 (dut) and MaxBurst=1 (dut1).
module tb_data_bus_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int MB = 4;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  v0, v1;
    logic [N*BW-1:0] d0, d1;
    logic [N-1:0]  ready0, ready1;
    logic          bvalid0, bvalid1;
    logic [BW-1:0] bdata0, bdata1;
    logic [1:0]    bowner0, bowner1;
    logic          idle0, idle1;
`ifdef DATA_BUS_ARB_STATS_EN
    logic [N*32-1:0] gcnt0, gcnt1;
    logic            cut0, cut1;
`endif

    int checks = 0;
    int passes = 0;

    data_bus_arbiter #(.NumReq(N), .BusWidth(BW), .MaxBurst(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(v0), .req_data_i(d0), .req_ready_o(ready0),
        .bus_valid_o(bvalid0), .bus_data_o(bdata0), .bus_owner_o(bowner0),
        .idle_o(idle0)
`ifdef DATA_BUS_ARB_STATS_EN
        , .grant_cnt_o(gcnt0), .burst_cut_o(cut0)
`endif
    );

    data_bus_arbiter #(.NumReq(N), .BusWidth(BW), .MaxBurst(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(v1), .req_data_i(d1), .req_ready_o(ready1),
        .bus_valid_o(bvalid1), .bus_data_o(bdata1), .bus_owner_o(bowner1),
        .idle_o(idle1)
`ifdef DATA_BUS_ARB_STATS_EN
        , .grant_cnt_o(gcnt1), .burst_cut_o(cut1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        v0 = '0; v1 = '0; d0 = '0; d1 = '0;
        tick;
        tick;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        v0 = 4'b1111; d0 = 32'hdeadbeef;
        v1 = 4'b1111; d1 = 32'h01234567;
        rst_n = 1'b0;
        tick;
        tick;
        checks++;
        if (ready0 !== 4'b0000) $display("FAIL rst_ready0: got %b want 0000", ready0);
        else passes++;
        checks++;
        if (ready1 !== 4'b0000) $display("FAIL rst_ready1: got %b want 0000", ready1);
        else passes++;
        checks++;
        if (bvalid0 !== 1'b0 || bvalid1 !== 1'b0)
            $display("FAIL rst_valid: got %b/%b want 0/0", bvalid0, bvalid1);
        else passes++;
        checks++;
        if (bdata0 !== 8'h00 || bowner0 !== 2'd0)
            $display("FAIL rst_data_owner: got %h/%0d want 00/0", bdata0, bowner0);
        else passes++;
        checks++;
        if (idle0 !== 1'b0) $display("FAIL rst_idle_busy: got %b want 0", idle0);
        else passes++;
        v0 = '0;
        #1;
        checks++;
        if (idle0 !== 1'b1) $display("FAIL rst_idle: got %b want 1", idle0);
        else passes++;
        v1 = '0;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single;
        do_reset;
        d0 = '0;
        d0[23:16] = 8'hA5;
        v0 = 4'b0100;
        #1;
        checks++;
        if (ready0 !== 4'b0100) $display("FAIL single_rdy0: got %b want 0100", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b1 || bdata0 !== 8'hA5 || bowner0 !== 2'd2)
            $display("FAIL single_bus0: got %b/%h/%0d want 1/a5/2", bvalid0, bdata0, bowner0);
        else passes++;
        d0[23:16] = 8'hA6;
        #1;
        checks++;
        if (ready0 !== 4'b0100) $display("FAIL single_rdy1: got %b want 0100", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b1 || bdata0 !== 8'hA6 || bowner0 !== 2'd2)
            $display("FAIL single_bus1: got %b/%h/%0d want 1/a6/2", bvalid0, bdata0, bowner0);
        else passes++;
        v0 = '0;
        #1;
        checks++;
        if (ready0 !== 4'b0000) $display("FAIL single_rdy_off: got %b want 0000", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b0 || bdata0 !== 8'hA6 || bowner0 !== 2'd2)
            $display("FAIL single_hold: got %b/%h/%0d want 0/a6/2", bvalid0, bdata0, bowner0);
        else passes++;
    endtask

    task automatic test_round_robin;
        int e;
        logic [BW-1:0] ed;
        do_reset;
        d0 = 32'h44332211;
        v0 = 4'b1111;
        #1;
        for (int k = 0; k < 20; k++) begin
            e  = (k / MB) % N;
            ed = d0[e*BW +: BW];
            checks++;
            if (ready0 !== 4'(1 << e))
                $display("FAIL rr_ready[%0d]: got %b want %b", k, ready0, 4'(1 << e));
            else passes++;
            tick;
            checks++;
            if (bvalid0 !== 1'b1 || bowner0 !== 2'(e) || bdata0 !== ed)
                $display("FAIL rr_bus[%0d]: got %b/%0d/%h want 1/%0d/%h",
                         k, bvalid0, bowner0, bdata0, e, ed);
            else passes++;
        end
        v0 = '0;
        tick;
    endtask

    task automatic test_maxburst1;
        int e;
        do_reset;
        d1 = 32'h44332211;
        v1 = 4'b1010;
        #1;
        for (int k = 0; k < 8; k++) begin
            e = (k % 2 == 0) ? 1 : 3;
            checks++;
            if (ready1 !== 4'(1 << e))
                $display("FAIL mb1_ready[%0d]: got %b want %b", k, ready1, 4'(1 << e));
            else passes++;
            tick;
            checks++;
            if (bvalid1 !== 1'b1 || bowner1 !== 2'(e))
                $display("FAIL mb1_bus[%0d]: got %b/%0d want 1/%0d", k, bvalid1, bowner1, e);
            else passes++;
        end
        v1 = '0;
        tick;
    endtask

    task automatic test_drop;
        do_reset;
        d0 = 32'h00C300C0;
        v0 = 4'b0101;
        #1;
        checks++;
        if (ready0 !== 4'b0001) $display("FAIL drop_rdy0: got %b want 0001", ready0);
        else passes++;
        tick;
        checks++;
        if (ready0 !== 4'b0001) $display("FAIL drop_rdy1: got %b want 0001", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b1 || bowner0 !== 2'd0)
            $display("FAIL drop_bus1: got %b/%0d want 1/0", bvalid0, bowner0);
        else passes++;
        v0 = 4'b0100;
        #1;
        checks++;
        if (ready0 !== 4'b0100) $display("FAIL drop_handover: got %b want 0100", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b1 || bowner0 !== 2'd2 || bdata0 !== 8'hC3)
            $display("FAIL drop_bus2: got %b/%0d/%h want 1/2/c3", bvalid0, bowner0, bdata0);
        else passes++;
        v0 = '0;
        tick;
    endtask

    task automatic test_reset_mid;
        do_reset;
        d0 = 32'h44332211;
        v0 = 4'b1111;
        tick;
        tick;
        checks++;
        if (bvalid0 !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", bvalid0);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bvalid0 !== 1'b0 || ready0 !== 4'b0000 || bdata0 !== 8'h00)
            $display("FAIL mid_clear: got %b/%b/%h want 0/0000/00", bvalid0, ready0, bdata0);
        else passes++;
        tick;
        checks++;
        if (ready0 !== 4'b0000) $display("FAIL mid_ready_rst: got %b want 0000", ready0);
        else passes++;
        rst_n = 1'b1;
        #1;
        checks++;
        if (ready0 !== 4'b0001) $display("FAIL mid_restart_rdy: got %b want 0001", ready0);
        else passes++;
        tick;
        checks++;
        if (bvalid0 !== 1'b1 || bowner0 !== 2'd0)
            $display("FAIL mid_restart_bus: got %b/%0d want 1/0", bvalid0, bowner0);
        else passes++;
        v0 = '0;
        tick;
    endtask

    // Reference: owner index (-1 = none), beats taken, round-robin start
    task automatic test_random;
        int m_cur, m_beats, m_ptr, eg, c;
        logic [N-1:0]  pend;
        logic [BW-1:0] pdata [N];
        logic [BW-1:0] last_d, ed;
        logic [1:0]    last_o;
        logic          e_idle;
        logic [N-1:0]  e_rdy;
        int errs;
        do_reset;
        m_cur = -1; m_beats = 0; m_ptr = 0;
        pend = '0; last_d = '0; last_o = '0;
        errs = 0;
        for (int i = 0; i < N; i++) pdata[i] = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 99) < 55) begin
                    pend[i]  = 1'b1;
                    pdata[i] = BW'($urandom);
                end
                d0[i*BW +: BW] = pdata[i];
            end
            v0 = pend;
            #1;
            e_idle = (m_cur < 0) && (v0 == '0);
            eg = -1;
            if (m_cur >= 0 && v0[m_cur]) begin
                eg = m_cur;
                m_beats++;
                if (m_beats == MB) m_cur = -1;
            end else begin
                m_cur = -1;
                for (int j = 0; j < N; j++) begin
                    c = (m_ptr + j) % N;
                    if (eg < 0 && v0[c]) eg = c;
                end
                if (eg >= 0) begin
                    m_ptr   = (eg + 1) % N;
                    m_cur   = eg;
                    m_beats = 1;
                end
            end
            e_rdy = (eg >= 0) ? 4'(1 << eg) : 4'b0000;
            checks++;
            if (idle0 !== e_idle) begin
                errs++;
                $display("FAIL rand_idle[%0d]: got %b want %b", cyc, idle0, e_idle);
            end else passes++;
            checks++;
            if (ready0 !== e_rdy) begin
                errs++;
                $display("FAIL rand_ready[%0d]: got %b want %b", cyc, ready0, e_rdy);
            end else passes++;
            if (eg >= 0) begin
                pend[eg] = 1'b0;
                last_d   = pdata[eg];
                last_o   = 2'(eg);
            end
            ed = last_d;
            tick;
            checks++;
            if (bvalid0 !== (eg >= 0) || bdata0 !== ed || bowner0 !== last_o) begin
                errs++;
                $display("FAIL rand_bus[%0d]: got %b/%h/%0d want %b/%h/%0d",
                         cyc, bvalid0, bdata0, bowner0, (eg >= 0), ed, last_o);
            end else passes++;
            if (errs > 20) break;
        end
        v0 = '0;
        tick;
    endtask

`ifdef DATA_BUS_ARB_STATS_EN
    task automatic test_stats;
        int cuts, acc, cyc;
        do_reset;
        cuts = 0;
        d0 = 32'h44332211;
        v0 = 4'b0010;
        #1;
        acc = 0; cyc = 0;
        while (acc < 10 && cyc < 40) begin
            if (ready0[1]) acc++;
            tick;
            if (cut0) cuts++;
            cyc++;
        end
        checks++;
        if (acc != 10) $display("FAIL stats_req1_budget: got %0d beats want 10", acc);
        else passes++;
        v0 = 4'b1000;
        #1;
        acc = 0; cyc = 0;
        while (acc < 3 && cyc < 40) begin
            if (ready0[3]) acc++;
            tick;
            if (cut0) cuts++;
            cyc++;
            if (acc == 3) v0 = '0;
        end
        v0 = '0;
        for (int k = 0; k < 4; k++) begin
            tick;
            if (cut0) cuts++;
        end
        checks++;
        if (gcnt0[31:0] !== 32'd0 || gcnt0[63:32] !== 32'd10 ||
            gcnt0[95:64] !== 32'd0 || gcnt0[127:96] !== 32'd3)
            $display("FAIL stats_cnt: got %0d,%0d,%0d,%0d want 0,10,0,3",
                     gcnt0[31:0], gcnt0[63:32], gcnt0[95:64], gcnt0[127:96]);
        else passes++;
        checks++;
        if (cuts != 2) $display("FAIL stats_cut: got %0d pulses want 2", cuts);
        else passes++;
        do_reset;
        checks++;
        if (gcnt0 !== '0 || cut0 !== 1'b0)
            $display("FAIL stats_reset: got %h/%b want 0/0", gcnt0, cut0);
        else passes++;
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        v0 = '0; v1 = '0; d0 = '0; d1 = '0;
        #2;
        test_reset;
        test_single;
        test_round_robin;
        test_maxburst1;
        test_drop;
        test_reset_mid;
        test_random;
`ifdef DATA_BUS_ARB_STATS_EN
        test_stats;
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
